// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Brief    : Releases up to NUM_STAGES active-low domain resets in order once
//            the PLL lock is stable, re-asserts all of them on lock loss,
//            watchdog expiry or software request, and records the cause.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 400,
  parameter int LOCK_FILT   = 16,
  parameter int HOLD_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock,
  input  logic                  wdt_expire,
  input  logic                  sw_reset_req,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  ready,
  output logic [1:0]            reset_cause
);

  // Counter width covers the longest interval any counter has to measure.
  localparam int REL_SPAN = STAGE_DELAY * (NUM_STAGES - 1);
  localparam int MAX_A    = (REL_SPAN > LOCK_FILT) ? REL_SPAN : LOCK_FILT;
  localparam int CNT_MAX  = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LOCK_FILT_C = CW'(LOCK_FILT);
  localparam logic [CW-1:0] HOLD_C      = CW'(HOLD_CYCLES);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    ASSERT    = 3'd4
  } state_t;

  state_t                  state, state_d;
  logic                    sync_ff1, lock_sync;
  logic [CW-1:0]           filt_cnt, filt_d;
  logic [CW-1:0]           stage_cnt, stage_d;
  logic [CW-1:0]           hold_cnt, hold_d;
  logic [NUM_STAGES-1:0]   rst_n_d;
  logic                    ready_d;
  logic [1:0]              cause_d;
  logic                    lock_loss, fault;
  logic [1:0]              fault_cause;
  logic [CW-1:0]           filt_inc, stage_inc, hold_inc;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff1  <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      sync_ff1  <= pll_lock;
      lock_sync <= sync_ff1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HOLD;
      filt_cnt    <= '0;
      stage_cnt   <= '0;
      hold_cnt    <= '0;
      rst_n_out   <= '0;
      ready       <= 1'b0;
      reset_cause <= CAUSE_POR;
    end else begin
      state       <= state_d;
      filt_cnt    <= filt_d;
      stage_cnt   <= stage_d;
      hold_cnt    <= hold_d;
      rst_n_out   <= rst_n_d;
      ready       <= ready_d;
      reset_cause <= cause_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d   = state;
    filt_d    = filt_cnt;
    stage_d   = stage_cnt;
    hold_d    = hold_cnt;
    rst_n_d   = rst_n_out;
    cause_d   = reset_cause;
    filt_inc  = sat_inc(filt_cnt);
    stage_inc = sat_inc(stage_cnt);
    hold_inc  = sat_inc(hold_cnt);

    // Lock loss is only a fault once domains have started releasing.
    lock_loss = !lock_sync && ((state == RELEASE) || (state == RUN));
    fault     = wdt_expire || sw_reset_req || lock_loss;
    if (wdt_expire)      fault_cause = CAUSE_WDT;
    else if (lock_loss)  fault_cause = CAUSE_LOCK;
    else if (sw_reset_req) fault_cause = CAUSE_SW;
    else                 fault_cause = reset_cause;

    case (state)
      HOLD: begin
        state_d = WAIT_LOCK;
        filt_d  = '0;
      end
      WAIT_LOCK, RELEASE, RUN: begin
        if (fault) begin
          state_d = ASSERT;
          hold_d  = '0;
          rst_n_d = '0;
          cause_d = fault_cause;
        end else if (state == WAIT_LOCK) begin
          if (!lock_sync) begin
            filt_d = '0;
          end else begin
            filt_d = filt_inc;
            if (filt_inc >= LOCK_FILT_C) begin
              state_d    = RELEASE;
              stage_d    = '0;
              rst_n_d[0] = 1'b1;
            end
          end
        end else if (state == RELEASE) begin
          if (&rst_n_out) begin
            state_d = RUN;
          end else begin
            stage_d = stage_inc;
            for (int k = 1; k < NUM_STAGES; k++) begin
              if (int'(stage_inc) >= k * STAGE_DELAY) rst_n_d[k] = 1'b1;
            end
          end
        end
      end
      ASSERT: begin
        rst_n_d = '0;
        // A new request during the hold window restarts the hold.
        if (wdt_expire || sw_reset_req) begin
          hold_d  = '0;
          cause_d = fault_cause;
        end else if (hold_inc >= HOLD_C) begin
          state_d = WAIT_LOCK;
          filt_d  = '0;
        end else begin
          hold_d = hold_inc;
        end
      end
      default: begin
        state_d = HOLD;
        rst_n_d = '0;
      end
    endcase

    ready_d = (state_d == RUN);
  end

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Brief    : Directed self-checking bench for reset_sequencer with
//            NUM_STAGES=3, STAGE_DELAY=4, LOCK_FILT=3, HOLD_CYCLES=5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       wdt_expire = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic [2:0] rst_n_out;
  logic       ready;
  logic [1:0] reset_cause;

  int checks = 0;
  int fails  = 0;

  reset_sequencer #(
    .NUM_STAGES (3),
    .STAGE_DELAY(4),
    .LOCK_FILT  (3),
    .HOLD_CYCLES(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_lock    (pll_lock),
    .wdt_expire  (wdt_expire),
    .sw_reset_req(sw_reset_req),
    .rst_n_out   (rst_n_out),
    .ready       (ready),
    .reset_cause (reset_cause)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Power-on with lock high: stage 0 at edge 5, 1 at 9, 2 at 13, ready at 14.
  task automatic test_reset();
    logic [2:0] exp_rn;
    rst = 1'b1; pll_lock = 1'b1;
    repeat (3) tick();
    checks++;
    if (rst_n_out !== 3'b000 || ready !== 1'b0 || reset_cause !== 2'b00) begin
      fails++;
      $display("FAIL reset_state: rst_n_out=%b ready=%b cause=%b, want 000/0/00",
               rst_n_out, ready, reset_cause);
    end
    rst = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      exp_rn = (e >= 13) ? 3'b111 : (e >= 9) ? 3'b011 : (e >= 5) ? 3'b001 : 3'b000;
      checks++;
      if (rst_n_out !== exp_rn) begin
        fails++;
        $display("FAIL poweron_stages edge %0d: rst_n_out=%b want %b", e, rst_n_out, exp_rn);
      end
      checks++;
      if (ready !== (e >= 14)) begin
        fails++;
        $display("FAIL poweron_ready edge %0d: ready=%b want %b", e, ready, (e >= 14));
      end
    end
    checks++;
    if (reset_cause !== 2'b00) begin
      fails++;
      $display("FAIL poweron_cause: cause=%b want 00", reset_cause);
    end
  endtask

  // Lock low for 10 cycles in RUN: asserted 3 edges later, re-release after relock.
  task automatic test_lock_loss();
    logic [2:0] exp_rn;
    logic       exp_rdy;
    pll_lock = 1'b0;
    for (int d = 1; d <= 24; d++) begin
      tick();
      if (d == 10) pll_lock = 1'b1;
      exp_rn  = (d < 3)  ? 3'b111 : (d <= 14) ? 3'b000 : (d <= 18) ? 3'b001 :
                (d <= 22) ? 3'b011 : 3'b111;
      exp_rdy = (d < 3) || (d >= 24);
      checks++;
      if (rst_n_out !== exp_rn || ready !== exp_rdy) begin
        fails++;
        $display("FAIL lock_loss edge %0d: rst_n_out=%b ready=%b want %b/%b",
                 d, rst_n_out, ready, exp_rn, exp_rdy);
      end
      if (d >= 3) begin
        checks++;
        if (reset_cause !== 2'b01) begin
          fails++;
          $display("FAIL lock_loss_cause edge %0d: cause=%b want 01", d, reset_cause);
        end
      end
    end
  endtask

  // Watchdog and software request on the same edge: watchdog wins.
  task automatic test_wdt_sw_same();
    wdt_expire = 1'b1; sw_reset_req = 1'b1;
    #2;
    checks++;
    if (rst_n_out !== 3'b111 || ready !== 1'b1) begin
      fails++;
      $display("FAIL no_comb_path: rst_n_out=%b ready=%b want 111/1", rst_n_out, ready);
    end
    tick();
    wdt_expire = 1'b0; sw_reset_req = 1'b0;
    checks++;
    if (rst_n_out !== 3'b000 || ready !== 1'b0 || reset_cause !== 2'b11) begin
      fails++;
      $display("FAIL wdt_sw_assert: rst_n_out=%b ready=%b cause=%b want 000/0/11",
               rst_n_out, ready, reset_cause);
    end
    // Hold ends at edge 6, filter of 3 releases stage 0 at edge 9.
    for (int d = 2; d <= 9; d++) begin
      tick();
      checks++;
      if (rst_n_out !== ((d == 9) ? 3'b001 : 3'b000)) begin
        fails++;
        $display("FAIL wdt_rerelease edge %0d: rst_n_out=%b want %b",
                 d, rst_n_out, ((d == 9) ? 3'b001 : 3'b000));
      end
    end
  endtask

  // Software request between stage 0 and stage 1 releases.
  task automatic test_sw_in_release();
    tick();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    checks++;
    if (rst_n_out !== 3'b000 || ready !== 1'b0 || reset_cause !== 2'b10) begin
      fails++;
      $display("FAIL sw_in_release: rst_n_out=%b ready=%b cause=%b want 000/0/10",
               rst_n_out, ready, reset_cause);
    end
  endtask

  // Request at the 3rd ASSERT cycle: hold restarts, WAIT_LOCK 5 edges later,
  // so stage 0 is released 3 edges after that (8 edges after the request).
  task automatic test_hold_restart();
    logic [2:0] exp_rn;
    tick(); tick();
    checks++;
    if (rst_n_out !== 3'b000) begin
      fails++;
      $display("FAIL no_stage1_release: rst_n_out=%b want 000", rst_n_out);
    end
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    for (int d = 4; d <= 11; d++) begin
      tick();
      exp_rn = (d == 11) ? 3'b001 : 3'b000;
      checks++;
      if (rst_n_out !== exp_rn) begin
        fails++;
        $display("FAIL hold_restart assert+%0d: rst_n_out=%b want %b", d, rst_n_out, exp_rn);
      end
    end
    checks++;
    if (reset_cause !== 2'b10) begin
      fails++;
      $display("FAIL hold_restart_cause: cause=%b want 10", reset_cause);
    end
  endtask

  // Asynchronous reset mid-RELEASE, checked before the next clock edge.
  task automatic test_async_reset();
    repeat (4) tick();
    checks++;
    if (rst_n_out !== 3'b011) begin
      fails++;
      $display("FAIL pre_async_stage1: rst_n_out=%b want 011", rst_n_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rst_n_out !== 3'b000 || ready !== 1'b0 || reset_cause !== 2'b00) begin
      fails++;
      $display("FAIL async_reset: rst_n_out=%b ready=%b cause=%b want 000/0/00",
               rst_n_out, ready, reset_cause);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (rst_n_out !== ((e == 5) ? 3'b001 : 3'b000)) begin
        fails++;
        $display("FAIL post_reset_release edge %0d: rst_n_out=%b want %b",
                 e, rst_n_out, ((e == 5) ? 3'b001 : 3'b000));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_loss();
    test_wdt_sw_same();
    test_sw_in_release();
    test_hold_restart();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Sequences release of the fabric reset domains from the simulation/board reset source and the PLL lock indication. Up to NUM_STAGES active-low domain resets are deasserted in a fixed order with a programmable gap between stages. All domains are re-asserted on PLL lock loss, watchdog expiry or software request, and the block records the cause. It sits between the top-level reset generator and the DM interface clock domains. It replaces ad-hoc per-module reset gating.

## Interface
Parameters:
- NUM_STAGES, 3, number of sequenced reset domains (1..8)
- STAGE_DELAY, 400, clk cycles between consecutive stage releases (≥1)
- LOCK_FILT, 16, consecutive synchronized lock-high cycles required before release (≥1)
- HOLD_CYCLES, 32, minimum cycles all domains stay asserted after a fault/request (≥1)

Ports:
- clk  in  1  system clock; the block's only clock
- rst  in  1  asynchronous, active-high reset (inverted RESET from the reset generator)
- pll_lock  in  1  PLL lock, asynchronous to clk
- wdt_expire  in  1  watchdog expiry, single-cycle pulse, clk domain
- sw_reset_req  in  1  software reset request, single-cycle pulse, clk domain
- rst_n_out  out  NUM_STAGES  per-domain active-low reset; bit 0 is released first
- ready  out  1  high when all domains are released (RUN state)
- reset_cause  out  2  last cause: 00 power-on, 01 lock loss, 10 software, 11 watchdog

## Operation
- pll_lock passes through a 2-flop synchronizer to produce lock_sync. The synchronizer is cleared by rst.
- FSM states: HOLD, WAIT_LOCK, RELEASE, RUN, ASSERT.
- HOLD: entered during rst. It exits to WAIT_LOCK on the first clk edge after rst deasserts.
- WAIT_LOCK:
  - The filter counter increments on each edge at which lock_sync=1, and clears when lock_sync=0.
  - When the counter reaches LOCK_FILT, the FSM enters RELEASE and rst_n_out[0] goes to 1 on the same edge.
- RELEASE:
  - A stage counter runs. rst_n_out[k] goes to 1 exactly k*STAGE_DELAY edges after RELEASE entry.
  - One edge after the last stage is released, the FSM enters RUN and ready goes to 1.
- RUN: holds until a fault or request occurs.
- Fault handling in WAIT_LOCK, RELEASE or RUN:
  - Trigger conditions are wdt_expire=1, sw_reset_req=1, or lock_sync=0 while in RELEASE/RUN.
  - On the next edge: all rst_n_out go to 0, ready goes to 0, reset_cause is updated, and the FSM enters ASSERT with the hold counter cleared.
  - Simultaneous events set reset_cause by priority: watchdog > lock loss > software.
- lock_sync=0 in WAIT_LOCK only clears the filter counter. It is not a fault and does not change reset_cause.
- ASSERT:
  - All domains stay asserted for HOLD_CYCLES edges, then the FSM goes to WAIT_LOCK with the filter counter cleared.
  - wdt_expire or sw_reset_req during ASSERT restarts the hold counter and updates reset_cause, using the same priority.
  - Lock state is ignored in ASSERT.
- reset_cause is sticky: it changes only on a new fault or on rst.
- Counter widths are sized by $clog2 of max(STAGE_DELAY*(NUM_STAGES-1), LOCK_FILT, HOLD_CYCLES)+1. Counters saturate and never wrap.

## Timing
- Reset values (rst=1): rst_n_out all 0, ready=0, reset_cause=00, state HOLD, all counters 0, synchronizer 0.
- rst is asynchronous: assertion forces the reset values immediately, mid-sequence or not.
- All outputs are registered; there is no combinational path from any input to any output.
- pll_lock to lock_sync latency: 2 edges.
- Release latency, with pll_lock already high and edge 1 being the first edge after rst falls:
  - stage 0 released at edge 3+LOCK_FILT−1 = LOCK_FILT+2
  - stage k released at LOCK_FILT+2+k*STAGE_DELAY
  - ready=1 one edge after the last stage
- Fault to all-asserted: 1 edge after wdt_expire/sw_reset_req is sampled; 3 edges after pll_lock falls (synchronizer plus 1).
- A lock glitch shorter than one clk may be missed. This is acceptable behaviour.

## Test plan
All scenarios use NUM_STAGES=3, STAGE_DELAY=4, LOCK_FILT=3, HOLD_CYCLES=5.
- Power-on, pll_lock high throughout, rst released before edge 1 → rst_n_out=001 at edge 5, 011 at edge 9, 111 at edge 13; ready=1 at edge 14; reset_cause=00.
- pll_lock drops for 10 cycles in RUN → rst_n_out=000 and ready=0 at 3 edges after the drop; reset_cause=01; domains stay asserted ≥5 edges and until relock, then re-release with 4-cycle spacing.
- wdt_expire and sw_reset_req pulsed on the same edge in RUN → rst_n_out=000 next edge; reset_cause=11.
- sw_reset_req during RELEASE (after stage 0, before stage 1) → all asserted next edge; reset_cause=10; stage 1 is never released before the restart.
- sw_reset_req at the 3rd cycle of ASSERT → hold restarts; WAIT_LOCK is entered 5 edges after the second request.
- rst asserted asynchronously mid-RELEASE → outputs return to reset values without waiting for a clk edge; reset_cause=00.
